// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port data memory between the MEM stage (P) and the loader (L).
// Build option DMEM_ARB_ROUND_ROBIN_EN replaces the starvation counter with round-robin arbitration.
module dmem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_stall,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              grant_p;
    logic              grant_l;
    logic              any_grant;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              cmd_own;
    logic              tag_v;
    logic              tag_own;

`ifdef DMEM_ARB_ROUND_ROBIN_EN

    logic last_owner;

    // Contended cycles go to whichever port did not win last time.
    always_comb begin
        grant_l = l_req & (~p_req | ~last_owner);
        grant_p = p_req & ~grant_l;
    end

    // Remember the owner of every grant (0 = P, 1 = L).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner <= 1'b0;
        end else if (grant_p | grant_l) begin
            last_owner <= grant_l;
        end
    end

`else

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;
    logic       force_l;

    // P wins by default; L is pushed through once it has waited long enough.
    always_comb begin
        force_l = (starve_cnt == STARVE_MAX) & l_req;
        grant_l = force_l | (l_req & ~p_req);
        grant_p = p_req & ~grant_l;
    end

    // Count consecutive denied L cycles, saturating at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 8'd0;
        end else if (!l_req || grant_l) begin
            starve_cnt <= 8'd0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

`endif

    // Select the winning requester's command fields.
    always_comb begin
        any_grant = grant_p | grant_l;
        win_we    = 1'b0;
        win_addr  = p_addr;
        win_wdata = p_wdata;
        unique case (1'b1)
            grant_l: begin
                win_we    = l_we;
                win_addr  = l_addr;
                win_wdata = l_wdata;
            end
            grant_p: begin
                win_we    = p_we;
                win_addr  = p_addr;
                win_wdata = p_wdata;
            end
            default: begin
                win_we    = 1'b0;
            end
        endcase
    end

    // Register the granted command; address and data hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cmd_own   <= 1'b0;
        end else if (any_grant) begin
            mem_en    <= 1'b1;
            mem_we    <= win_we;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            cmd_own   <= grant_l;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    // Track the owner of the read whose data the memory returns next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v   <= 1'b0;
            tag_own <= 1'b0;
        end else begin
            tag_v   <= mem_en & ~mem_we;
            tag_own <= cmd_own;
        end
    end

    assign l_gnt    = grant_l;
    assign p_stall  = p_req & ~grant_p;
    assign p_rvalid = tag_v & ~tag_own;
    assign l_rvalid = tag_v & tag_own;
    assign p_rdata  = mem_rdata;
    assign l_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected read
// responses; a negedge monitor pops and compares owner, data and arrival cycle.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p_req = 1'b0, p_we = 1'b0;
    logic [9:0]  p_addr = '0;
    logic [31:0] p_wdata = '0;
    logic        p_stall, p_rvalid;
    logic [31:0] p_rdata;
    logic        l_req = 1'b0, l_we = 1'b0;
    logic [9:0]  l_addr = '0;
    logic [31:0] l_wdata = '0;
    logic        l_gnt, l_rvalid;
    logic [31:0] l_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [1024];

    typedef struct {
        bit          own;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port synchronous memory array.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (rst && (p_rvalid || l_rvalid)) begin
            chk("both_rvalid", 32'(p_rvalid & l_rvalid), 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_rvalid", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_owner", 32'(l_rvalid), 32'(e.own));
                chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                chk("resp_data", e.own ? l_rdata : p_rdata, e.data);
            end
        end
    end

    task automatic step(
        input logic pr, input logic pw, input logic [9:0] pa, input logic [31:0] pd,
        input logic lr, input logic lw, input logic [9:0] la, input logic [31:0] ld,
        input logic es, input logic eg, input logic [31:0] ed, input bit resp
    );
        logic gp;
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
        gp = pr & ~es;
        @(negedge clk);
        chk("p_stall", 32'(p_stall), 32'(es));
        chk("l_gnt", 32'(l_gnt), 32'(eg));
        if (resp && ((eg && !lw) || (gp && !pw))) begin
            q.push_back('{own: eg, data: ed, cyc: cyc + 2});
        end
        @(posedge clk);
        #1;
        chk("mem_en", 32'(mem_en), 32'(gp | eg));
        if (gp | eg) begin
            chk("mem_addr", 32'(mem_addr), 32'(eg ? la : pa));
            chk("mem_we", 32'(mem_we), 32'(eg ? lw : pw));
            if (eg ? lw : pw) chk("mem_wdata", mem_wdata, eg ? ld : pd);
        end else begin
            chk("mem_we_idle", 32'(mem_we), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0, 0, 0, 32'h0, 0);
    endtask

    task automatic chk_reset_outs();
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_p_rvalid", 32'(p_rvalid), 32'd0);
        chk("rst_l_rvalid", 32'(l_rvalid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[5] = 32'hDEADBEEF;
        mem[1] = 32'h11111111;
        mem[2] = 32'h22222222;
        mem[3] = 32'h33333333;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit lw_turn;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs();
        p_req = 1'b1;
        #1;
        chk("rst_p_stall", 32'(p_stall), 32'd0);
        chk("rst_l_gnt", 32'(l_gnt), 32'd0);
        p_req = 1'b0;
        rst = 1'b1;

        // P read of a preloaded word.
        step(1, 0, 10'h005, 32'h0, 0, 0, 10'h0, 32'h0, 0, 0, 32'hDEADBEEF, 1);
        idle(3);

        // P write then L read of the same address.
        step(1, 1, 10'h010, 32'h12345678, 0, 0, 10'h0, 32'h0, 0, 0, 32'h0, 1);
        step(0, 0, 10'h0, 32'h0, 1, 0, 10'h010, 32'h0, 0, 1, 32'h12345678, 1);
        idle(3);

        // L back-to-back reads.
        step(0, 0, 10'h0, 32'h0, 1, 0, 10'h001, 32'h0, 0, 1, 32'h11111111, 1);
        step(0, 0, 10'h0, 32'h0, 1, 0, 10'h002, 32'h0, 0, 1, 32'h22222222, 1);
        step(0, 0, 10'h0, 32'h0, 1, 0, 10'h003, 32'h0, 0, 1, 32'h33333333, 1);
        idle(3);

        // Same address written by P then L, then read back by P.
        step(1, 1, 10'h020, 32'hAAAA0000, 0, 0, 10'h0, 32'h0, 0, 0, 32'h0, 1);
        step(0, 0, 10'h0, 32'h0, 1, 1, 10'h020, 32'hBBBB0000, 0, 1, 32'h0, 1);
        step(1, 0, 10'h020, 32'h0, 0, 0, 10'h0, 32'h0, 0, 0, 32'hBBBB0000, 1);
        idle(3);

        // P read granted, then reset before its data returns.
        step(1, 0, 10'h005, 32'h0, 0, 0, 10'h0, 32'h0, 0, 0, 32'h0, 0);
        rst = 1'b0;
        #1;
        chk_reset_outs();
        @(negedge clk);
        chk_reset_outs();
        p_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Both ports request continuously straight out of reset.
        for (int i = 1; i <= 18; i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            lw_turn = (i % 2) == 1;
`else
            lw_turn = (i % 9) == 0;
`endif
            step(1, 0, 10'h005, 32'h0, 1, 0, 10'h001, 32'h0, lw_turn, lw_turn,
                 lw_turn ? 32'h11111111 : 32'hDEADBEEF, 1);
        end
        idle(4);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the pipeline MEM stage (port P) and the program/data loader (port L).
- Sits between the MEM stage and the data-memory array; the array is driven only from this block's registered command outputs.
- P has priority. A starvation counter guarantees that L makes forward progress.
- Each read response is returned to the requester that issued the read, tagged by owner.

Parameters:
- ADDR_W, 10, word-address width of the data memory.
- DATA_W, 32, data width.
- STARVE_LIMIT, 8, number of consecutive denied L cycles before L is forced through. Legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- p_req  in  1  MEM-stage access request.
- p_we  in  1  1 = write, 0 = read.
- p_addr  in  ADDR_W  MEM-stage word address.
- p_wdata  in  DATA_W  MEM-stage write data.
- p_stall  out  1  p_req is held off this cycle; the MEM stage must freeze.
- p_rvalid  out  1  read data for P is valid this cycle.
- p_rdata  out  DATA_W  read data for P.
- l_req  in  1  loader request.
- l_we  in  1  loader write enable.
- l_addr  in  ADDR_W  loader address.
- l_wdata  in  DATA_W  loader write data.
- l_gnt  out  1  loader request accepted this cycle.
- l_rvalid  out  1  read data for L is valid this cycle.
- l_rdata  out  DATA_W  read data for L.
- mem_en  out  1  memory access enable (registered).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en & !mem_we.

Behaviour:
Arbitration (combinational within cycle N):
- force_l = (starve_cnt == STARVE_LIMIT) & l_req.
- Grant goes to L if force_l, or if l_req & !p_req. Otherwise grant goes to P when p_req.
- l_gnt is 1 iff L is granted. p_stall = p_req & !(P granted).
- Requesters hold their req/we/addr/wdata stable until granted.

Command stage (posedge ending cycle N):
- If a grant was given: mem_en <= 1; mem_we, mem_addr and mem_wdata are taken from the winner. mem_we is 0 for reads.
- If no grant: mem_en <= 0 and mem_we <= 0; mem_addr and mem_wdata hold their previous values.

Response tag:
- tag_v <= mem_en & !mem_we, and tag_own <= owner of the issued command (0 = P, 1 = L), both registered on the same edge as the command.

Response (cycle N+2):
- p_rvalid = tag_v & !tag_own; l_rvalid = tag_v & tag_own.
- p_rdata and l_rdata both equal mem_rdata. Only the rvalid strobe qualifies the data.
- Read latency from grant to rvalid is exactly 2 cycles. Writes produce no response.
- Back-to-back grants give one access per cycle. Responses return in issue order.

Starvation counter (8 bits):
- Cleared when l_req = 0 or when L is granted.
- Otherwise incremented each cycle that l_req = 1 and L is denied, saturating at STARVE_LIMIT.

Reset (rst = 0, asynchronous):
- mem_en, mem_we, mem_addr, mem_wdata, tag_v, tag_own and starve_cnt go to 0.
- Hence p_rvalid = l_rvalid = 0 after reset.
- Any in-flight read is dropped; no response appears after reset is released.
- p_stall and l_gnt follow the arbitration equations with starve_cnt = 0.

Boundary cases:
- P and L both write the same address in consecutive grants: memory order equals grant order.
- A read granted in the cycle after a write to the same address returns the newly written data.
- p_req = l_req = 0: the bus is idle and mem_en = 0.

Optional Feature:
Macro: DMEM_ARB_ROUND_ROBIN_EN
- Defined:
  - The starvation counter is removed and a 1-bit last_owner register (reset 0) is added.
  - When both ports request, the winner is the port that is not last_owner.
  - last_owner updates on every grant.
  - STARVE_LIMIT is ignored.
- Not defined: fixed priority with the starvation counter, as described under Behaviour.

Test Plan:
- Reset release, P reads addr 0x005 with memory word 0x005 = 0xDEADBEEF -> mem_en=1, mem_addr=0x005 one cycle after grant; p_rvalid=1 with p_rdata=0xDEADBEEF 2 cycles after grant; l_rvalid stays 0.
- P writes 0x12345678 to 0x010, next cycle L reads 0x010 -> l_gnt=1 on the second cycle; l_rvalid=1 with 0x12345678 2 cycles later; p_stall=0 throughout.
- P and L request continuously, STARVE_LIMIT=8 -> L granted on cycle 9 with p_stall=1 that cycle only; pattern repeats every 9 cycles.
- P read granted, then rst asserted the next cycle -> p_rvalid never asserts; all mem_* outputs are 0 while rst = 0.
- With DMEM_ARB_ROUND_ROBIN_EN, P and L both request continuously -> grants alternate P, L, P, L starting with L (last_owner resets to 0); each port's p_stall/l_gnt toggles every cycle.
- L issues 3 back-to-back reads (0x001, 0x002, 0x003), P idle -> l_gnt=1 for 3 cycles; l_rvalid high for 3 consecutive cycles, returning the data in order.
